// File: rtl/fixed_cls_pos_embed.sv
// Prepends a class token to the patch-embed token stream and adds a positional beat to every beat.
// Output is rounded (floor) and saturated to OUT_WIDTH, one registered beat with a valid/ready handshake.
//
// state   | meaning
// S_CLS   | emitting the C_BEATS class-token beats of a frame
// S_PATCH | emitting NUM_PATCH patch tokens of C_BEATS beats each
module fixed_cls_pos_embed #(
  parameter int IN_WIDTH       = 6,
  parameter int IN_FRAC_WIDTH  = 1,
  parameter int POS_WIDTH      = 6,
  parameter int POS_FRAC_WIDTH = 1,
  parameter int OUT_WIDTH      = 6,
  parameter int OUT_FRAC_WIDTH = 1,
  parameter int OUT_C          = 4,
  parameter int UNROLL_C       = 2,
  parameter int NUM_PATCH      = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [UNROLL_C-1:0][IN_WIDTH-1:0]    data_in_0,
  input  logic                                 data_in_0_valid,
  output logic                                 data_in_0_ready,
  input  logic [UNROLL_C-1:0][IN_WIDTH-1:0]    cls_in,
  input  logic                                 cls_valid,
  output logic                                 cls_ready,
  input  logic [UNROLL_C-1:0][POS_WIDTH-1:0]   pos_in,
  input  logic                                 pos_valid,
  output logic                                 pos_ready,
  output logic [UNROLL_C-1:0][OUT_WIDTH-1:0]   data_out_0,
  output logic                                 data_out_0_valid,
  input  logic                                 data_out_0_ready
);

  localparam int C_BEATS = OUT_C / UNROLL_C;
  localparam int BEAT_W  = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
  localparam int TOK_W   = (NUM_PATCH > 1) ? $clog2(NUM_PATCH) : 1;

  localparam int F      = (IN_FRAC_WIDTH > POS_FRAC_WIDTH) ? IN_FRAC_WIDTH : POS_FRAC_WIDTH;
  localparam int SH_IN  = F - IN_FRAC_WIDTH;
  localparam int SH_POS = F - POS_FRAC_WIDTH;
  localparam int A_W    = IN_WIDTH + SH_IN;
  localparam int P_W    = POS_WIDTH + SH_POS;
  localparam int SUM_W  = ((A_W > P_W) ? A_W : P_W) + 1;
  localparam int SH_UP  = (OUT_FRAC_WIDTH > F) ? OUT_FRAC_WIDTH - F : 0;
  localparam int SH_DN  = (F > OUT_FRAC_WIDTH) ? F - OUT_FRAC_WIDTH : 0;
  localparam int WIDE0  = SUM_W + SH_UP;
  localparam int WIDE   = (WIDE0 > OUT_WIDTH + 1) ? WIDE0 : OUT_WIDTH + 1;

  localparam logic signed [WIDE-1:0] MAXV = {{(WIDE-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [WIDE-1:0] MINV = ~MAXV;

  typedef enum logic {S_CLS, S_PATCH} state_t;

  state_t                              state_q;
  logic [BEAT_W-1:0]                   beat_cnt_q;
  logic [TOK_W-1:0]                    tok_cnt_q;
  logic                                out_valid_q;
  logic [UNROLL_C-1:0][OUT_WIDTH-1:0]  out_data_q;
  logic [UNROLL_C-1:0][OUT_WIDTH-1:0]  out_data_d;

  logic                                is_cls;
  logic                                load_en;
  logic                                src_valid;
  logic [UNROLL_C-1:0][IN_WIDTH-1:0]   src_data;
  logic                                fire;
  logic                                beat_last;
  logic                                tok_last;

  assign is_cls    = (state_q == S_CLS);
  assign load_en   = !out_valid_q || data_out_0_ready;
  assign src_valid = is_cls ? cls_valid : data_in_0_valid;
  assign src_data  = is_cls ? cls_in : data_in_0;
  assign fire      = !rst && src_valid && pos_valid && load_en;
  assign beat_last = (beat_cnt_q == BEAT_W'(C_BEATS - 1));
  assign tok_last  = (tok_cnt_q == TOK_W'(NUM_PATCH - 1));

  // Join: each ready looks only at the partner's valid, so all operands leave on the same edge.
  assign cls_ready       = !rst && is_cls && pos_valid && load_en;
  assign data_in_0_ready = !rst && !is_cls && pos_valid && load_en;
  assign pos_ready       = !rst && load_en && (is_cls ? cls_valid : data_in_0_valid);

  always_comb begin
    out_data_d = '0;
    for (int l = 0; l < UNROLL_C; l++) begin
      logic signed [WIDE-1:0] a_ext;
      logic signed [WIDE-1:0] p_ext;
      logic signed [WIDE-1:0] sum;
      a_ext = WIDE'($signed(src_data[l]));
      p_ext = WIDE'($signed(pos_in[l]));
      sum   = (a_ext <<< SH_IN) + (p_ext <<< SH_POS);
      sum   = (sum <<< SH_UP) >>> SH_DN;
      if (sum > MAXV)
        out_data_d[l] = MAXV[OUT_WIDTH-1:0];
      else if (sum < MINV)
        out_data_d[l] = MINV[OUT_WIDTH-1:0];
      else
        out_data_d[l] = sum[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLS;
      beat_cnt_q  <= '0;
      tok_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (load_en)
        out_valid_q <= fire;
      if (fire) begin
        out_data_q <= out_data_d;
        beat_cnt_q <= beat_last ? '0 : beat_cnt_q + 1'b1;
        case (state_q)
          S_CLS: begin
            if (beat_last)
              state_q <= S_PATCH;
          end
          S_PATCH: begin
            if (beat_last) begin
              if (tok_last) begin
                tok_cnt_q <= '0;
                state_q   <= S_CLS;
              end else begin
                tok_cnt_q <= tok_cnt_q + 1'b1;
              end
            end
          end
          default: state_q <= S_CLS;
        endcase
      end
    end
  end

  assign data_out_0       = out_data_q;
  assign data_out_0_valid = out_valid_q;

endmodule

// File: tb/tb_fixed_cls_pos_embed.sv
// Directed bench for fixed_cls_pos_embed: full frames, backpressure, random gaps, mid-frame reset,
// plus a second instance with mismatched fractional widths for the alignment/floor case.
module tb_fixed_cls_pos_embed;

  localparam int CB    = 2;
  localparam int NP    = 64;
  localparam int FRAME = CB * (NP + 1);

  typedef logic [1:0][5:0] beat_t;

  logic  clk;
  logic  rst;
  beat_t data_in_0, cls_in, pos_in, data_out_0;
  logic  data_in_0_valid, data_in_0_ready, cls_valid, cls_ready, pos_valid, pos_ready;
  logic  data_out_0_valid, data_out_0_ready;

  beat_t b_cls_in, b_pos_in, b_data_in_0, b_data_out_0;
  logic  b_data_in_0_valid, b_data_in_0_ready, b_cls_valid, b_cls_ready, b_pos_valid, b_pos_ready;
  logic  b_data_out_0_valid, b_data_out_0_ready;

  fixed_cls_pos_embed dut (
    .clk(clk), .rst(rst),
    .data_in_0(data_in_0), .data_in_0_valid(data_in_0_valid), .data_in_0_ready(data_in_0_ready),
    .cls_in(cls_in), .cls_valid(cls_valid), .cls_ready(cls_ready),
    .pos_in(pos_in), .pos_valid(pos_valid), .pos_ready(pos_ready),
    .data_out_0(data_out_0), .data_out_0_valid(data_out_0_valid), .data_out_0_ready(data_out_0_ready)
  );

  fixed_cls_pos_embed #(.POS_FRAC_WIDTH(2), .OUT_FRAC_WIDTH(0), .NUM_PATCH(1)) dut_b (
    .clk(clk), .rst(rst),
    .data_in_0(b_data_in_0), .data_in_0_valid(b_data_in_0_valid), .data_in_0_ready(b_data_in_0_ready),
    .cls_in(b_cls_in), .cls_valid(b_cls_valid), .cls_ready(b_cls_ready),
    .pos_in(b_pos_in), .pos_valid(b_pos_valid), .pos_ready(b_pos_ready),
    .data_out_0(b_data_out_0), .data_out_0_valid(b_data_out_0_valid), .data_out_0_ready(b_data_out_0_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    passed = 0;
  int    total  = 0;
  beat_t cls_q[$], patch_q[$], pos_q[$], obs_q[$];
  int    ci, pi, qi, oi, n_cls, n_patch, n_pos, ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] p);
    int s;
    s = int'($signed(a)) + int'($signed(p));
    if (s > 31) s = 31;
    if (s < -32) s = -32;
    return 6'(s);
  endfunction

  function automatic beat_t exp_beat(input int n);
    int    fr, k, si;
    beat_t s, r;
    fr = n / FRAME;
    k  = n % FRAME;
    if (n >= pos_q.size()) return '1;
    if (k < CB) begin
      si = fr * CB + k;
      if (si >= cls_q.size()) return '1;
      s = cls_q[si];
    end else begin
      si = fr * CB * NP + k - CB;
      if (si >= patch_q.size()) return '1;
      s = patch_q[si];
    end
    for (int l = 0; l < 2; l++) r[l] = sat_add(s[l], pos_q[n][l]);
    return r;
  endfunction

  task automatic add_frame();
    for (int i = 0; i < CB; i++) cls_q.push_back(12'($urandom));
    for (int i = 0; i < CB * NP; i++) patch_q.push_back(12'($urandom));
    for (int i = 0; i < FRAME; i++) pos_q.push_back(12'($urandom));
  endtask

  task automatic clear_model();
    cls_q.delete(); patch_q.delete(); pos_q.delete(); obs_q.delete();
    ci = 0; pi = 0; qi = 0; oi = 0; n_cls = 0; n_patch = 0; n_pos = 0; ncyc = 0;
  endtask

  // One clock: drive sources from the queues, sample handshakes mid-cycle, advance after the edge.
  task automatic cycle(input bit rdy, input int gap);
    bit ac, ap, aq;
    cls_valid       = (ci < cls_q.size()) && ($urandom_range(99) >= gap);
    cls_in          = (ci < cls_q.size()) ? cls_q[ci] : '0;
    data_in_0_valid = (pi < patch_q.size()) && ($urandom_range(99) >= gap);
    data_in_0       = (pi < patch_q.size()) ? patch_q[pi] : '0;
    pos_valid       = (qi < pos_q.size()) && ($urandom_range(99) >= gap);
    pos_in          = (qi < pos_q.size()) ? pos_q[qi] : '0;
    data_out_0_ready = rdy;
    #4;
    ac = cls_valid && cls_ready;
    ap = data_in_0_valid && data_in_0_ready;
    aq = pos_valid && pos_ready;
    if (ac || ap || aq) chk("join", {30'd0, ac && ap, aq}, {30'd0, 1'b0, ac || ap});
    if (data_out_0_valid && data_out_0_ready) begin
      obs_q.push_back(data_out_0);
      chk($sformatf("beat%0d", oi), 32'(data_out_0), 32'(exp_beat(oi)));
      oi++;
    end
    @(posedge clk); #1;
    if (ac) begin ci++; n_cls++; end
    if (ap) begin pi++; n_patch++; end
    if (aq) begin qi++; n_pos++; end
    ncyc++;
  endtask

  initial begin
    rst = 1'b1;
    cls_valid = 0; data_in_0_valid = 0; pos_valid = 0; data_out_0_ready = 0;
    cls_in = '0; data_in_0 = '0; pos_in = '0;
    b_cls_in = {6'h3F, 6'h03}; b_pos_in = {6'h3F, 6'h03}; b_data_in_0 = '0;
    b_cls_valid = 1; b_pos_valid = 1; b_data_in_0_valid = 0; b_data_out_0_ready = 1;
    clear_model();

    // Reset state, with every valid high so the readys must be forced low by rst.
    repeat (2) @(posedge clk);
    #1;
    cls_valid = 1; data_in_0_valid = 1; pos_valid = 1; data_out_0_ready = 1;
    #1;
    chk("rst_valid", 32'(data_out_0_valid), 32'd0);
    chk("rst_data", 32'(data_out_0), 32'd0);
    chk("rst_readys", {29'd0, cls_ready, data_in_0_ready, pos_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame 1: directed cls/pos beats for lane add and saturation, rest random.
    cls_q.push_back({6'd31, 6'd3});
    cls_q.push_back({6'd10, 6'h20});
    pos_q.push_back({6'd1, 6'd2});
    pos_q.push_back({6'h3B, 6'h3F});
    for (int i = 0; i < CB * NP; i++) patch_q.push_back(12'($urandom));
    for (int i = CB; i < FRAME; i++) pos_q.push_back(12'($urandom));

    cycle(1, 0);
    chk("align_valid", 32'(b_data_out_0_valid), 32'd1);
    chk("align_floor", 32'(b_data_out_0), 32'({6'h3F, 6'd2}));
    while (oi < FRAME && ncyc < 1000) cycle(1, 0);
    chk("f1_beats", oi, FRAME);
    chk("f1_cycles", ncyc, FRAME + 1);
    chk("f1_cls_acc", n_cls, CB);
    chk("f1_patch_acc", n_patch, CB * NP);
    chk("f1_pos_acc", n_pos, FRAME);
    chk("lane_add_sat_hi", 32'(obs_q[0]), 32'({6'd31, 6'd5}));
    chk("lane_sat_lo", 32'(obs_q[1]), 32'({6'd5, 6'h20}));

    // Frame 2: stall downstream for 5 cycles mid-token.
    add_frame();
    ncyc = 0;
    while (oi < FRAME + 5 && ncyc < 1000) cycle(1, 0);
    chk("bp_reach", oi, FRAME + 5);
    for (int i = 0; i < 5; i++) begin
      data_out_0_ready = 0;
      #4;
      chk("bp_readys", {29'd0, cls_ready, data_in_0_ready, pos_ready}, 32'd0);
      @(posedge clk); #1;
      chk("bp_valid", 32'(data_out_0_valid), 32'd1);
      chk("bp_hold", 32'(data_out_0), 32'(exp_beat(FRAME + 5)));
    end
    ncyc = 0;
    while (oi < 2 * FRAME && ncyc < 1000) cycle(1, 0);
    chk("f2_beats", oi, 2 * FRAME);
    chk("f2_cls_acc", n_cls, 2 * CB);
    chk("f2_patch_acc", n_patch, 2 * CB * NP);

    // Frames 3-5: random gaps on all inputs and random downstream ready.
    repeat (3) add_frame();
    ncyc = 0;
    while (oi < 5 * FRAME && ncyc < 6000) cycle(bit'($urandom_range(99) >= 30), 30);
    chk("rnd_beats", oi, 5 * FRAME);
    chk("rnd_cls_acc", n_cls, 5 * CB);
    chk("rnd_patch_acc", n_patch, 5 * CB * NP);
    chk("rnd_pos_acc", n_pos, 5 * FRAME);

    // Mid-frame reset after token 10.
    add_frame();
    ncyc = 0;
    while (oi < 5 * FRAME + 11 * CB && ncyc < 1000) cycle(1, 0);
    chk("pre_rst_reach", oi, 5 * FRAME + 11 * CB);
    rst = 1'b1;
    cls_valid = 1; data_in_0_valid = 1; pos_valid = 1; data_out_0_ready = 1;
    #4;
    chk("mid_rst_readys", {29'd0, cls_ready, data_in_0_ready, pos_ready}, 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_valid", 32'(data_out_0_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out_0), 32'd0);
    rst = 1'b0;
    clear_model();
    add_frame();
    cycle(1, 0);
    chk("post_rst_cls_first", n_cls, 1);
    chk("post_rst_no_patch", n_patch, 0);
    while (oi < FRAME && ncyc < 1000) cycle(1, 0);
    chk("post_rst_beats", oi, FRAME);
    chk("post_rst_cls_acc", n_cls, CB);
    chk("post_rst_patch_acc", n_patch, CB * NP);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
